reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 167 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Merges button/sw/watchdog requests into one reset event: assert all stages, hold, release lowest first.
// Latency: sw/wdt 1 cycle, button 2+DEBOUNCE_CYCLES+1 cycles; no backpressure, requests are never dropped.
module reset_sequencer #(
    parameter int DEBOUNCE_CYCLES   = 1000,
    parameter int MIN_ASSERT_CYCLES = 16,
    parameter int NUM_STAGES        = 3,
    parameter int STAGE_GAP_CYCLES  = 8,
    parameter int COUNT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  reset_in,
    input  logic                  button_n,
    input  logic                  sw_req,
    input  logic                  wdt_req,
    output logic [NUM_STAGES-1:0] stage_reset_out,
    output logic                  busy,
    output logic [1:0]            cause
);

    localparam logic [COUNT_WIDTH-1:0] DEB_LAST  = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] HOLD_LAST = COUNT_WIDTH'(MIN_ASSERT_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] GAP_LAST  = COUNT_WIDTH'(STAGE_GAP_CYCLES - 1);
    localparam logic [NUM_STAGES-1:0]  LAST_ONE  = NUM_STAGES'(1) << (NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_IDLE    = 2'd2
    } state_t;

    logic                   btn_meta;
    logic                   btn_sync;
    logic                   btn_deb;
    logic                   btn_req;
    logic [COUNT_WIDTH-1:0] deb_cnt;

    always_ff @(posedge clk) begin
        if (reset_in) begin
            btn_meta <= 1'b1;
            btn_sync <= 1'b1;
            btn_deb  <= 1'b1;
            btn_req  <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            btn_meta <= button_n;
            btn_sync <= btn_meta;
            btn_req  <= 1'b0;
            if (btn_sync == btn_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt <= '0;
                btn_deb <= btn_sync;
                // old debounced value 1 means this flip is a press
                btn_req <= btn_deb;
            end else begin
                deb_cnt <= deb_cnt + COUNT_WIDTH'(1);
            end
        end
    end

    logic                   request;
    logic                   last_stage;
    logic [NUM_STAGES-1:0]  stage_shifted;
    state_t                 state;
    state_t                 state_nxt;
    logic [COUNT_WIDTH-1:0] cnt;
    logic [COUNT_WIDTH-1:0] cnt_nxt;
    logic [NUM_STAGES-1:0]  stage_nxt;
    logic                   busy_nxt;
    logic [1:0]             cause_nxt;

    assign request       = btn_req | sw_req | wdt_req;
    // Shifting a zero in from bit 0 releases the next stage in index order.
    assign stage_shifted = stage_reset_out << 1;
    assign last_stage    = (stage_reset_out == LAST_ONE);

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state           <= ST_HOLD;
            cnt             <= '0;
            stage_reset_out <= '1;
            busy            <= 1'b1;
            cause           <= 2'b00;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            stage_reset_out <= stage_nxt;
            busy            <= busy_nxt;
            cause           <= cause_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (request) begin
            state_nxt = ST_HOLD;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (!btn_deb) begin
                        cnt_nxt = '0;
                    end else if (cnt == HOLD_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = last_stage ? ST_IDLE : ST_RELEASE;
                    end else begin
                        cnt_nxt = cnt + COUNT_WIDTH'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        cnt_nxt = '0;
                        if (last_stage) begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt + COUNT_WIDTH'(1);
                    end
                end
                ST_IDLE: begin
                    cnt_nxt = '0;
                end
                default: begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        stage_nxt = stage_reset_out;
        cause_nxt = cause;
        if (request) begin
            stage_nxt = '1;
            if (wdt_req) begin
                cause_nxt = 2'b11;
            end else if (sw_req) begin
                cause_nxt = 2'b10;
            end else begin
                cause_nxt = 2'b01;
            end
        end else begin
            case (state)
                ST_HOLD: begin
                    if (btn_deb && (cnt == HOLD_LAST)) begin
                        stage_nxt = stage_shifted;
                    end
                end
                ST_RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        stage_nxt = stage_shifted;
                    end
                end
                ST_IDLE: begin
                    stage_nxt = '0;
                end
                default: begin
                    stage_nxt = '1;
                end
            endcase
        end
        busy_nxt = |stage_nxt;
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: two instances (default and minimal parameters) against a timeline model.
module tb_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_in;
    logic       button_n;
    logic       sw_req;
    logic       wdt_req;
    logic [2:0] stage_a;
    logic       busy_a;
    logic [1:0] cause_a;
    logic [0:0] stage_b;
    logic       busy_b;
    logic [1:0] cause_b;

    reset_sequencer #(
        .DEBOUNCE_CYCLES(1000), .MIN_ASSERT_CYCLES(16), .NUM_STAGES(3),
        .STAGE_GAP_CYCLES(8), .COUNT_WIDTH(16)
    ) u_a (
        .clk(clk), .reset_in(reset_in), .button_n(button_n), .sw_req(sw_req),
        .wdt_req(wdt_req), .stage_reset_out(stage_a), .busy(busy_a), .cause(cause_a)
    );

    reset_sequencer #(
        .DEBOUNCE_CYCLES(4), .MIN_ASSERT_CYCLES(1), .NUM_STAGES(1),
        .STAGE_GAP_CYCLES(1), .COUNT_WIDTH(8)
    ) u_b (
        .clk(clk), .reset_in(reset_in), .button_n(button_n), .sw_req(sw_req),
        .wdt_req(wdt_req), .stage_reset_out(stage_b), .busy(busy_b), .cause(cause_b)
    );

    int vectors     = 0;
    int miscompares = 0;

    function automatic int p_deb(input int j); return (j == 0) ? 1000 : 4; endfunction
    function automatic int p_min(input int j); return (j == 0) ? 16 : 1;   endfunction
    function automatic int p_nst(input int j); return (j == 0) ? 3 : 1;    endfunction
    function automatic int p_gap(input int j); return (j == 0) ? 8 : 1;    endfunction

    // Model: each event (reset, request, or a cycle with the button held) pins an anchor edge;
    // stage i is then asserted until MIN + i*GAP edges past the anchor.
    int       ecnt    = 0;
    bit       started = 1'b0;
    int       anchor [2];
    bit       s1 [2];
    bit       s2 [2];
    bit       deb [2];
    bit       bpend [2];
    int       run [2];
    bit [1:0] mcause [2];
    bit       nd;
    bit       rq;

    always @(posedge clk) begin
        ecnt = ecnt + 1;
        if (reset_in) started = 1'b1;
        for (int j = 0; j < 2; j++) begin
            if (reset_in) begin
                s1[j] = 1'b1; s2[j] = 1'b1; deb[j] = 1'b1; bpend[j] = 1'b0;
                run[j] = 0; anchor[j] = ecnt; mcause[j] = 2'b00;
            end else begin
                rq = bpend[j] || sw_req || wdt_req;
                nd = deb[j];
                if (s2[j] != deb[j]) begin
                    run[j] = run[j] + 1;
                    if (run[j] >= p_deb(j)) begin
                        nd = ~deb[j];
                        run[j] = 0;
                    end
                end else begin
                    run[j] = 0;
                end
                if (rq) begin
                    anchor[j] = ecnt;
                    mcause[j] = wdt_req ? 2'b11 : (sw_req ? 2'b10 : 2'b01);
                end else if (!deb[j]) begin
                    anchor[j] = ecnt;
                end
                bpend[j] = deb[j] && !nd;
                deb[j]   = nd;
                s2[j]    = s1[j];
                s1[j]    = button_n;
            end
        end
    end

    function automatic logic [2:0] exp_stage(input int j);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < p_nst(j); i++) begin
            r[i] = ((ecnt - anchor[j]) < (p_min(j) + i * p_gap(j)));
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            logic [2:0] ea;
            logic [2:0] eb;
            ea = exp_stage(0);
            eb = exp_stage(1);
            vectors = vectors + 2;
            if (stage_a !== ea || busy_a !== (|ea) || cause_a !== mcause[0]) begin
                miscompares = miscompares + 1;
                $display("FAIL model_a edge=%0d: got stage=%b busy=%b cause=%b, want stage=%b busy=%b cause=%b",
                         ecnt, stage_a, busy_a, cause_a, ea, |ea, mcause[0]);
            end
            if ({2'b00, stage_b} !== eb || busy_b !== (|eb) || cause_b !== mcause[1]) begin
                miscompares = miscompares + 1;
                $display("FAIL model_b edge=%0d: got stage=%b busy=%b cause=%b, want stage=%b busy=%b cause=%b",
                         ecnt, stage_b, busy_b, cause_b, eb[0], |eb, mcause[1]);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        vectors = vectors + 1;
        if (got != exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int hold_left;

    initial begin
        reset_in = 1'b1; button_n = 1'b1; sw_req = 1'b0; wdt_req = 1'b0;
        tick(5);
        reset_in = 1'b0;

        tick(1);
        check("rst_a_e1", int'(stage_a), 7);
        check("rst_b_e1", int'(stage_b), 0);
        check("rst_b_busy_e1", int'(busy_b), 0);
        tick(14);
        check("rst_a_e15", int'(stage_a), 7);
        tick(1);
        check("rst_a_e16", int'(stage_a), 6);
        tick(8);
        check("rst_a_e24", int'(stage_a), 4);
        tick(7);
        check("rst_busy_e31", int'(busy_a), 1);
        tick(1);
        check("rst_a_e32", int'(stage_a), 0);
        check("rst_busy_e32", int'(busy_a), 0);
        check("rst_cause", int'(cause_a), 0);

        tick(4);
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        check("sw_assert", int'(stage_a), 7);
        check("sw_cause", int'(cause_a), 2);
        tick(15);
        check("sw_e15", int'(stage_a), 7);
        tick(1);
        check("sw_e16", int'(stage_a), 6);
        tick(8);
        check("sw_e24", int'(stage_a), 4);
        tick(8);
        check("sw_e32", int'(stage_a), 0);

        sw_req = 1'b1; wdt_req = 1'b1;
        tick(1);
        sw_req = 1'b0; wdt_req = 1'b0;
        check("both_cause", int'(cause_a), 3);
        tick(20);
        check("wdt_pre_e20", int'(stage_a), 6);
        wdt_req = 1'b1;
        tick(1);
        wdt_req = 1'b0;
        check("wdt_e21", int'(stage_a), 7);
        tick(15);
        check("wdt_e36", int'(stage_a), 7);
        tick(1);
        check("wdt_e37", int'(stage_a), 6);
        tick(40);

        sw_req = 1'b1;
        tick(1);
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check("b2b_b_stage", int'(stage_b), 1);
        end
        sw_req = 1'b0;
        tick(1);
        check("b2b_b_release", int'(stage_b), 0);
        check("b2b_b_busy", int'(busy_b), 0);
        tick(40);

        for (int k = 0; k < 20; k++) begin
            button_n = (k % 2 == 0) ? 1'b0 : 1'b1;
            tick(100);
        end
        check("bounce_busy", int'(busy_a), 0);
        check("bounce_cause", int'(cause_a), 2);

        button_n = 1'b0;
        tick(1002);
        check("press_e1002", int'(stage_a), 0);
        tick(1);
        check("press_e1003", int'(stage_a), 7);
        check("press_cause", int'(cause_a), 1);
        tick(3000);
        check("held_stage", int'(stage_a), 7);
        button_n = 1'b1;
        tick(1017);
        check("unpress_e1017", int'(stage_a), 7);
        tick(1);
        check("unpress_e1018", int'(stage_a), 6);
        tick(40);

        hold_left = 0;
        for (int c = 0; c < 20000; c++) begin
            sw_req   = ($urandom_range(0, 63) == 0);
            wdt_req  = ($urandom_range(0, 79) == 0);
            reset_in = ($urandom_range(0, 2999) == 0);
            if (hold_left <= 0) begin
                button_n  = ~button_n;
                hold_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1000, 2500))
                                                        : int'($urandom_range(1, 60));
            end
            hold_left = hold_left - 1;
            tick(1);
        end
        reset_in = 1'b0; sw_req = 1'b0; wdt_req = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
